// File: rtl/umi_burst_to_sb_if.sv
// Bundle of UMI input channels and the switchboard output word for umi_burst_to_sb.
// The slave modport is the packer; the master modport is whatever feeds and drains it.
interface umi_burst_to_sb_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned DW  = 256,
    parameter int unsigned AW  = 64,
    parameter int unsigned CW  = 32
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SBW = DW + 2 * AW + CW;

    logic [NCH-1:0]    umi_in_valid;
    logic [NCH-1:0]    umi_in_ready;
    logic [NCH-1:0]    umi_in_last;
    logic [NCH*CW-1:0] umi_in_cmd;
    logic [NCH*AW-1:0] umi_in_dstaddr;
    logic [NCH*AW-1:0] umi_in_srcaddr;
    logic [NCH*DW-1:0] umi_in_data;

    logic              sb_valid;
    logic              sb_ready;
    logic [SBW-1:0]    sb_data;
    logic [31:0]       sb_dest;
    logic              sb_last;
    logic [CHW-1:0]    sb_chan;
    logic              burst_err;

    modport master (
        output umi_in_valid,
        input  umi_in_ready,
        output umi_in_last,
        output umi_in_cmd,
        output umi_in_dstaddr,
        output umi_in_srcaddr,
        output umi_in_data,
        input  sb_valid,
        output sb_ready,
        input  sb_data,
        input  sb_dest,
        input  sb_last,
        input  sb_chan,
        input  burst_err
    );

    modport slave (
        input  umi_in_valid,
        output umi_in_ready,
        input  umi_in_last,
        input  umi_in_cmd,
        input  umi_in_dstaddr,
        input  umi_in_srcaddr,
        input  umi_in_data,
        output sb_valid,
        input  sb_ready,
        output sb_data,
        output sb_dest,
        output sb_last,
        output sb_chan,
        output burst_err
    );
endinterface

// File: rtl/umi_burst_to_sb.sv
// Round-robin, burst-locking packer from NCH UMI channels into one registered
// switchboard word stream; bursts longer than MAXBEATS are cut and flagged.
module umi_burst_to_sb #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned DW       = 256,
    parameter int unsigned AW       = 64,
    parameter int unsigned CW       = 32,
    parameter int unsigned DEST_LSB = 40,
    parameter int unsigned DEST_W   = 16,
    parameter int unsigned MAXBEATS = 256
) (
    input  logic              clk,
    input  logic              nreset,
    umi_burst_to_sb_if.slave  bus
);
    localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SBW  = DW + 2 * AW + CW;
    localparam int unsigned CNTW = $clog2(MAXBEATS + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t          state_q;
    logic [CHW-1:0]  ptr_q;
    logic [CHW-1:0]  lock_q;
    logic [CNTW-1:0] cnt_q;

    logic            sb_valid_q;
    logic [SBW-1:0]  sb_data_q;
    logic [31:0]     sb_dest_q;
    logic            sb_last_q;
    logic [CHW-1:0]  sb_chan_q;
    logic            burst_err_q;

    logic            can_load_d;
    logic [CHW-1:0]  grant_d;
    logic            grant_vld_d;
    logic [CHW:0]    scan_d;
    logic [NCH-1:0]  ready_d;
    logic            acc_d;
    logic            beat_last_d;
    logic            forced_d;
    logic            end_d;
    logic [CNTW-1:0] cnt_d;
    logic [CHW-1:0]  ptr_nxt_d;
    logic [CW-1:0]   cmd_d;
    logic [AW-1:0]   dst_d;
    logic [AW-1:0]   src_d;
    logic [DW-1:0]   data_d;
    logic [31:0]     dest_d;

    assign can_load_d = !sb_valid_q || bus.sb_ready;

    // Idle search starts at the pointer and wraps; a burst pins the grant to the locked channel.
    always_comb begin
        grant_d     = lock_q;
        grant_vld_d = 1'b0;
        scan_d      = '0;
        if (state_q == ST_BURST) begin
            grant_vld_d = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                scan_d = {1'b0, ptr_q} + (CHW+1)'(k);
                if (scan_d >= (CHW+1)'(NCH)) begin
                    scan_d = scan_d - (CHW+1)'(NCH);
                end
                if (!grant_vld_d && bus.umi_in_valid[scan_d[CHW-1:0]]) begin
                    grant_d     = scan_d[CHW-1:0];
                    grant_vld_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready_d = '0;
        if (nreset && grant_vld_d && can_load_d) begin
            ready_d[grant_d] = 1'b1;
        end
    end

    always_comb begin
        cmd_d       = bus.umi_in_cmd[grant_d*CW +: CW];
        dst_d       = bus.umi_in_dstaddr[grant_d*AW +: AW];
        src_d       = bus.umi_in_srcaddr[grant_d*AW +: AW];
        data_d      = bus.umi_in_data[grant_d*DW +: DW];
        beat_last_d = bus.umi_in_last[grant_d];
        acc_d       = ready_d[grant_d] && bus.umi_in_valid[grant_d];
        cnt_d       = (state_q == ST_IDLE) ? CNTW'(1) : cnt_q + CNTW'(1);
        forced_d    = !beat_last_d && (cnt_d == CNTW'(MAXBEATS));
        end_d       = beat_last_d || forced_d;
        ptr_nxt_d   = (grant_d == CHW'(NCH - 1)) ? '0 : grant_d + CHW'(1);
        dest_d                = '0;
        dest_d[DEST_W-1:0]    = dst_d[DEST_LSB +: DEST_W];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            lock_q      <= '0;
            cnt_q       <= '0;
            sb_valid_q  <= 1'b0;
            sb_data_q   <= '0;
            sb_dest_q   <= '0;
            sb_last_q   <= 1'b0;
            sb_chan_q   <= '0;
            burst_err_q <= 1'b0;
        end else begin
            burst_err_q <= 1'b0;
            if (acc_d) begin
                sb_valid_q  <= 1'b1;
                sb_data_q   <= {data_d, src_d, dst_d, cmd_d};
                sb_last_q   <= end_d;
                sb_chan_q   <= grant_d;
                burst_err_q <= forced_d;
                cnt_q       <= cnt_d;
                if (state_q == ST_IDLE) begin
                    sb_dest_q <= dest_d;
                end
                if (end_d) begin
                    state_q <= ST_IDLE;
                    ptr_q   <= ptr_nxt_d;
                end else begin
                    state_q <= ST_BURST;
                    lock_q  <= grant_d;
                end
            end else if (bus.sb_ready) begin
                sb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.umi_in_ready = ready_d;
    assign bus.sb_valid     = sb_valid_q;
    assign bus.sb_data      = sb_data_q;
    assign bus.sb_dest      = sb_dest_q;
    assign bus.sb_last      = sb_last_q;
    assign bus.sb_chan      = sb_chan_q;
    assign bus.burst_err    = burst_err_q;
endmodule

// File: tb/tb_umi_burst_to_sb.sv
// Directed bench for umi_burst_to_sb: a burst-level arbitration model predicts the
// output word stream, and a per-cycle compare process checks the DUT against it.
module tb_umi_burst_to_sb;
    localparam int unsigned NCH  = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 64;
    localparam int unsigned CW   = 32;
    localparam int unsigned MAXB = 4;
    localparam int unsigned SBW  = DW + 2 * AW + CW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [CW-1:0] cmd;
        logic          last;
    } beat_t;

    typedef struct {
        logic [SBW-1:0] data;
        logic [31:0]    dest;
        logic           last;
        logic [1:0]     chan;
        logic           forced;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    umi_burst_to_sb_if #(.NCH(NCH), .DW(DW), .AW(AW), .CW(CW)) bus ();

    umi_burst_to_sb #(
        .NCH(NCH), .DW(DW), .AW(AW), .CW(CW),
        .DEST_LSB(40), .DEST_W(16), .MAXBEATS(MAXB)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus)
    );

    beat_t       stim[NCH][16];
    int unsigned stim_n[NCH];
    int unsigned stim_i[NCH];
    exp_t        expq[$];
    int unsigned mptr = 0;

    int unsigned obs_chan[$];
    logic        obs_last[$];
    logic [31:0] obs_dest[$];
    int unsigned err_pulses = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [SBW-1:0] act, input logic [SBW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic beat_t mk(input int unsigned ch, input int unsigned k, input logic last);
        beat_t b;
        b.data = 32'hD000_0000 | DW'(ch << 8) | DW'(k);
        b.dst  = {8'h00, 8'(ch), 8'(k), 8'hA0, 32'(ch * 16 + k)};
        b.src  = 64'h5000_0000_0000_0000 | AW'(ch << 8) | AW'(k);
        b.cmd  = 32'hC000_0000 | CW'(ch << 8) | CW'(k);
        b.last = last;
        return b;
    endfunction

    task automatic begin_scn();
        for (int unsigned c = 0; c < NCH; c++) begin
            stim_n[c] = 0;
            stim_i[c] = 0;
        end
        obs_chan.delete();
        obs_last.delete();
        obs_dest.delete();
        err_pulses = 0;
    endtask

    // lastmask bit k marks beat k+1 of the channel's sequence as last.
    task automatic load(input int unsigned ch, input int unsigned n, input logic [15:0] lastmask);
        for (int unsigned k = 0; k < n; k++) begin
            stim[ch][k] = mk(ch, k + 1, lastmask[k]);
        end
        stim_n[ch] = n;
    endtask

    // Burst-level model: pick the next channel with work from the pointer, take beats
    // until last or the MAXB cap, then move the pointer past that channel.
    function automatic void run_model();
        int unsigned pos[NCH];
        int unsigned c, ch, cnt;
        logic [31:0] dest;
        beat_t       b;
        exp_t        e;
        bit          found, ended;
        for (int unsigned i = 0; i < NCH; i++) pos[i] = 0;
        c = 0;
        dest = '0;
        while (1) begin
            found = 0;
            for (int unsigned k = 0; k < NCH; k++) begin
                ch = (mptr + k) % NCH;
                if (!found && pos[ch] < stim_n[ch]) begin
                    c = ch;
                    found = 1;
                end
            end
            if (!found) break;
            cnt = 0;
            ended = 0;
            while (!ended && pos[c] < stim_n[c]) begin
                b = stim[c][pos[c]];
                pos[c]++;
                cnt++;
                if (cnt == 1) dest = 32'((b.dst >> 40) & 64'hFFFF);
                e.forced = !b.last && (cnt == MAXB);
                e.last   = b.last || e.forced;
                e.data   = {b.data, b.src, b.dst, b.cmd};
                e.dest   = dest;
                e.chan   = c[1:0];
                expq.push_back(e);
                ended = e.last;
            end
            mptr = (c + 1) % NCH;
        end
    endfunction

    task automatic drive();
        beat_t b;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (stim_i[c] < stim_n[c]) b = stim[c][stim_i[c]];
            else b = '0;
            bus.umi_in_valid[c]               = (stim_i[c] < stim_n[c]);
            bus.umi_in_last[c]                = b.last;
            bus.umi_in_cmd[c*CW +: CW]        = b.cmd;
            bus.umi_in_dstaddr[c*AW +: AW]    = b.dst;
            bus.umi_in_srcaddr[c*AW +: AW]    = b.src;
            bus.umi_in_data[c*DW +: DW]       = b.data;
        end
    endtask

    function automatic bit all_consumed();
        for (int unsigned c = 0; c < NCH; c++) begin
            if (stim_i[c] != stim_n[c]) return 0;
        end
        return 1;
    endfunction

    task automatic wait_done(input string name);
        int unsigned cyc;
        bit done;
        cyc = 0;
        done = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #2;
            done = (expq.size() == 0) && !bus.sb_valid && all_consumed();
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: %0d words still owed, required 0", name, expq.size());
        end
    endtask

    // Input driver: sample handshakes away from the edge, advance after it.
    initial begin
        bit fire[NCH];
        begin_scn();
        drive();
        forever begin
            @(negedge clk);
            for (int unsigned c = 0; c < NCH; c++) fire[c] = bus.umi_in_valid[c] && bus.umi_in_ready[c];
            @(posedge clk);
            #1;
            for (int unsigned c = 0; c < NCH; c++) if (fire[c]) stim_i[c]++;
            drive();
        end
    end

    // Per-cycle compare against the model's expected word stream.
    initial begin
        bit   new_word;
        exp_t e;
        new_word = 1;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                new_word = 1;
            end else begin
                check("ready_onehot", SBW'($countones(bus.umi_in_ready) <= 1), SBW'(1));
                if (bus.burst_err) err_pulses++;
                if (bus.sb_valid && !bus.sb_ready) check("stall_ready", SBW'(bus.umi_in_ready), '0);
                if (bus.sb_valid) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got chan %0d data %0h, required no word", bus.sb_chan, bus.sb_data);
                    end else begin
                        e = expq[0];
                        check("sb_data", bus.sb_data, e.data);
                        check("sb_dest", SBW'(bus.sb_dest), SBW'(e.dest));
                        check("sb_last", SBW'(bus.sb_last), SBW'(e.last));
                        check("sb_chan", SBW'(bus.sb_chan), SBW'(e.chan));
                        check("burst_err", SBW'(bus.burst_err), SBW'(new_word && e.forced));
                        if (bus.sb_ready) begin
                            void'(expq.pop_front());
                            obs_chan.push_back(int'(bus.sb_chan));
                            obs_last.push_back(bus.sb_last);
                            obs_dest.push_back(bus.sb_dest);
                        end
                    end
                end else begin
                    check("burst_err_idle", SBW'(bus.burst_err), '0);
                end
                new_word = !(bus.sb_valid && !bus.sb_ready);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rr_exp[6];
        int unsigned lock_exp[5];
        logic        lock_last[5];
        logic        frc_last[6];
        rr_exp    = '{0, 1, 2, 3, 0, 1};
        lock_exp  = '{0, 0, 0, 0, 1};
        lock_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        frc_last  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.sb_ready = 1'b1;

        #12;
        check("rst_sb_valid", SBW'(bus.sb_valid), '0);
        check("rst_sb_data", bus.sb_data, '0);
        check("rst_sb_dest", SBW'(bus.sb_dest), '0);
        check("rst_sb_last", SBW'(bus.sb_last), '0);
        check("rst_sb_chan", SBW'(bus.sb_chan), '0);
        check("rst_burst_err", SBW'(bus.burst_err), '0);
        check("rst_ready", SBW'(bus.umi_in_ready), '0);
        @(posedge clk);
        #2 nreset = 1'b1;

        // Round robin: every channel holds two single-beat bursts.
        @(posedge clk);
        begin_scn();
        for (int unsigned c = 0; c < NCH; c++) load(c, 2, 16'h0003);
        run_model();
        wait_done("rr");
        check("rr_count", SBW'(obs_chan.size()), SBW'(8));
        for (int unsigned i = 0; i < 6; i++) check("rr_chan_seq", SBW'(obs_chan[i]), SBW'(rr_exp[i]));

        // Burst lock: ch0 4-beat burst while ch1 waits with one beat.
        @(posedge clk);
        begin_scn();
        load(0, 4, 16'h0008);
        load(1, 1, 16'h0001);
        run_model();
        wait_done("lock");
        check("lock_count", SBW'(obs_chan.size()), SBW'(5));
        for (int unsigned i = 0; i < 5; i++) begin
            check("lock_chan_seq", SBW'(obs_chan[i]), SBW'(lock_exp[i]));
            check("lock_last_seq", SBW'(obs_last[i]), SBW'(lock_last[i]));
        end
        for (int unsigned i = 0; i < 4; i++) check("lock_dest", SBW'(obs_dest[i]), SBW'(32'h0000_0001));

        // Single beat on ch0; bits [55:40] of this address are 16'h0012.
        @(posedge clk);
        begin_scn();
        stim[0][0] = mk(0, 1, 1'b1);
        stim[0][0].dst = 64'h0000_1234_5600_0000;
        stim_n[0] = 1;
        run_model();
        #2;
        check("single_ready", SBW'(bus.umi_in_ready), SBW'(4'b0001));
        @(posedge clk);
        #2;
        check("single_valid", SBW'(bus.sb_valid), SBW'(1));
        check("single_dest", SBW'(bus.sb_dest), SBW'(32'h0000_0012));
        check("single_last", SBW'(bus.sb_last), SBW'(1));
        check("single_chan", SBW'(bus.sb_chan), SBW'(0));
        wait_done("single");

        // Backpressure: 3 stalled cycles in the middle of a ch2 burst, ch3 queued behind.
        @(posedge clk);
        begin_scn();
        load(2, 4, 16'h0008);
        load(3, 1, 16'h0001);
        run_model();
        repeat (2) @(posedge clk);
        #2 bus.sb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 bus.sb_ready = 1'b1;
        wait_done("bp");
        check("bp_count", SBW'(obs_chan.size()), SBW'(5));
        check("bp_first_chan", SBW'(obs_chan[0]), SBW'(2));
        check("bp_last_chan", SBW'(obs_chan[4]), SBW'(3));

        // Forced termination: ch1 sends 6 beats, last only on beat 6.
        @(posedge clk);
        begin_scn();
        load(1, 6, 16'h0020);
        run_model();
        wait_done("forced");
        check("forced_count", SBW'(obs_chan.size()), SBW'(6));
        check("forced_err_pulses", SBW'(err_pulses), SBW'(1));
        for (int unsigned i = 0; i < 6; i++) check("forced_last_seq", SBW'(obs_last[i]), SBW'(frc_last[i]));
        check("forced_dest_b4", SBW'(obs_dest[3]), SBW'(32'h0000_0101));
        check("forced_dest_b5", SBW'(obs_dest[4]), SBW'(32'h0000_0105));
        check("forced_dest_b6", SBW'(obs_dest[5]), SBW'(32'h0000_0105));

        // Reset during beat 2 of a 3-beat ch0 burst.
        @(posedge clk);
        begin_scn();
        load(0, 3, 16'h0004);
        run_model();
        @(posedge clk);
        #3 nreset = 1'b0;
        #1;
        check("midrst_sb_valid", SBW'(bus.sb_valid), '0);
        check("midrst_ready", SBW'(bus.umi_in_ready), '0);
        check("midrst_sb_last", SBW'(bus.sb_last), '0);
        begin_scn();
        expq.delete();
        mptr = 0;
        repeat (2) @(posedge clk);
        #2 nreset = 1'b1;
        @(posedge clk);
        begin_scn();
        load(1, 1, 16'h0001);
        load(2, 1, 16'h0001);
        run_model();
        #2;
        check("postrst_ready", SBW'(bus.umi_in_ready), SBW'(4'b0010));
        wait_done("postrst");
        check("postrst_count", SBW'(obs_chan.size()), SBW'(2));
        check("postrst_first_chan", SBW'(obs_chan[0]), SBW'(1));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
